// File: rtl/tdm_pkg.sv
//==============================================================================
// Module   : tdm_pkg
// Brief    : Shared types and constants for the TDM demux and mux blocks.
// Revision : 1.0
//==============================================================================
`default_nettype none

package tdm_pkg;

    localparam int TDM_WIDTH    = 5;
    localparam int TDM_CHANNELS = 4;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RUN  = 1'b1
    } tdm_state_e;

    // Slot counter width; never narrower than one bit.
    function automatic int slot_width(input int channels);
        return (channels <= 2) ? 1 : $clog2(channels);
    endfunction

endpackage : tdm_pkg

`default_nettype wire

// File: rtl/tdm_demux5_if.sv
//==============================================================================
// Module   : tdm_demux5_if
// Brief    : Multiplexed input stream plus per-channel handshake bundle.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface tdm_demux5_if #(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4
);
    logic [WIDTH-1:0]          InData;
    logic                      InValid;
    logic                      FrameSync;
    logic [CHANNELS-1:0]       ChanAck;
    logic [CHANNELS*WIDTH-1:0] ChanData;
    logic [CHANNELS-1:0]       ChanValid;
    logic [CHANNELS-1:0]       Overrun;
    logic                      FrameDone;
    logic                      SyncError;
    logic                      Locked;

    // Master: the stream source together with the channel consumers.
    modport master (
        output InData, InValid, FrameSync, ChanAck,
        input  ChanData, ChanValid, Overrun, FrameDone, SyncError, Locked
    );

    modport slave (
        input  InData, InValid, FrameSync, ChanAck,
        output ChanData, ChanValid, Overrun, FrameDone, SyncError, Locked
    );
endinterface : tdm_demux5_if

`default_nettype wire

// File: rtl/demux_chan_reg.sv
//==============================================================================
// Module   : demux_chan_reg
// Brief    : One channel holding register with valid/ack handshake and overrun.
// Revision : 1.0
//==============================================================================
`default_nettype none

module demux_chan_reg #(
    parameter int WIDTH = 5
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             wr_en,
    input  wire logic [WIDTH-1:0] wr_data,
    input  wire logic             ack,
    output logic      [WIDTH-1:0] data,
    output logic                  valid,
    output logic                  overrun
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    // A write always wins over an ack landing in the same cycle.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (wr_en) begin
            data_d    = wr_data;
            valid_d   = 1'b1;
            overrun_d = valid_q & ~ack;
        end else if (ack) begin
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;

endmodule : demux_chan_reg

`default_nettype wire

// File: rtl/tdm_demux5.sv
//==============================================================================
// Module   : tdm_demux5
// Brief    : Frame-synchronised TDM demultiplexer into per-channel registers.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tdm_demux5
    import tdm_pkg::*;
#(
    parameter int WIDTH    = TDM_WIDTH,
    parameter int CHANNELS = TDM_CHANNELS
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    tdm_demux5_if.slave   bus
);

    localparam int SW = slot_width(CHANNELS);
    localparam logic [SW-1:0] LAST_SLOT = SW'(CHANNELS - 1);

    tdm_state_e       state_q, state_d;
    logic [SW-1:0]    slot_q, slot_d;
    logic             frame_done_q, frame_done_d;
    logic             sync_error_q, sync_error_d;

    logic             wr_any;
    logic [SW-1:0]    wr_idx;
    logic [CHANNELS-1:0] wr_en;

    logic [WIDTH-1:0]    chan_data [CHANNELS];
    logic [CHANNELS-1:0] chan_valid;
    logic [CHANNELS-1:0] chan_overrun;

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        frame_done_d = 1'b0;
        sync_error_d = 1'b0;
        wr_any       = 1'b0;
        wr_idx       = '0;

        if (int'(slot_q) >= CHANNELS) begin
            // Unreachable counter value: drop lock and hunt for a fresh frame.
            state_d = HUNT;
            slot_d  = '0;
        end else if (bus.InValid) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.FrameSync) begin
                        wr_any  = 1'b1;
                        wr_idx  = '0;
                        slot_d  = SW'(1);
                        state_d = RUN;
                    end
                end
                RUN: begin
                    wr_any = 1'b1;
                    if (bus.FrameSync) begin
                        wr_idx       = '0;
                        slot_d       = SW'(1);
                        sync_error_d = (slot_q != '0);
                    end else begin
                        wr_idx = slot_q;
                        if (slot_q == LAST_SLOT) begin
                            slot_d       = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            slot_d = slot_q + SW'(1);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            slot_q       <= '0;
            frame_done_q <= 1'b0;
            sync_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            frame_done_q <= frame_done_d;
            sync_error_q <= sync_error_d;
        end
    end

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            assign wr_en[i] = wr_any && (wr_idx == SW'(i));

            demux_chan_reg #(
                .WIDTH (WIDTH)
            ) u_chan (
                .clk     (clk),
                .rst_n   (rst_n),
                .wr_en   (wr_en[i]),
                .wr_data (bus.InData),
                .ack     (bus.ChanAck[i]),
                .data    (chan_data[i]),
                .valid   (chan_valid[i]),
                .overrun (chan_overrun[i])
            );
        end
    endgenerate

    always_comb begin
        bus.ChanData = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.ChanData[i*WIDTH +: WIDTH] = chan_data[i];
        end
    end

    assign bus.ChanValid = chan_valid;
    assign bus.Overrun   = chan_overrun;
    assign bus.FrameDone = frame_done_q;
    assign bus.SyncError = sync_error_q;
    assign bus.Locked    = (state_q == RUN);

endmodule : tdm_demux5

`default_nettype wire

// File: tb/tb_tdm_demux5.sv
//==============================================================================
// Module   : tb_tdm_demux5
// Brief    : Directed self-checking bench for tdm_demux5.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_tdm_demux5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tdm_demux5_if #(.WIDTH(5), .CHANNELS(4)) bus ();

    tdm_demux5 #(.WIDTH(5), .CHANNELS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one input cycle, then sample 1 time unit after the edge.
    task automatic drive(input logic v, input logic [4:0] d, input logic s, input logic [3:0] a);
        bus.InValid   = v;
        bus.InData    = d;
        bus.FrameSync = s;
        bus.ChanAck   = a;
        @(posedge clk);
        #1;
        bus.InValid   = 1'b0;
        bus.FrameSync = 1'b0;
        bus.ChanAck   = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 5'h00, 1'b0, 4'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  {12'h0, bus.ChanData}, 32'h0);
        check({tag, "_valid"}, {28'h0, bus.ChanValid}, 32'h0);
        check({tag, "_ovr"},   {28'h0, bus.Overrun}, 32'h0);
        check({tag, "_flags"}, {29'h0, bus.FrameDone, bus.SyncError, bus.Locked}, 32'h0);
    endtask

    logic [4:0] frame [4];

    initial begin
        bus.InValid   = 1'b0;
        bus.InData    = '0;
        bus.FrameSync = 1'b0;
        bus.ChanAck   = '0;
        frame[0] = 5'h01; frame[1] = 5'h02; frame[2] = 5'h03; frame[3] = 5'h04;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(1);

        // Unsynchronised words are dropped while hunting
        drive(1'b1, 5'h1F, 1'b0, 4'h0);
        drive(1'b1, 5'h1E, 1'b0, 4'h0);
        check_all_zero("hunt_discard");

        // First frame, back-to-back
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, frame[j], (j == 0), 4'h0);
            check($sformatf("f1_ovr%0d", j), {28'h0, bus.Overrun}, 32'h0);
            check($sformatf("f1_done%0d", j), {31'h0, bus.FrameDone}, (j == 3) ? 32'h1 : 32'h0);
        end
        check("f1_data",   {12'h0, bus.ChanData}, {12'h0, 5'h04, 5'h03, 5'h02, 5'h01});
        check("f1_valid",  {28'h0, bus.ChanValid}, 32'hF);
        check("f1_locked", {31'h0, bus.Locked}, 32'h1);
        idle(1);
        check("f1_done_pulse", {31'h0, bus.FrameDone}, 32'h0);

        // Second frame with no acks: each write overruns its channel
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 5'(5 + j), (j == 0), 4'h0);
            check($sformatf("f2_ovr%0d", j), {28'h0, bus.Overrun}, 32'(1 << j));
        end
        check("f2_data", {12'h0, bus.ChanData}, {12'h0, 5'h08, 5'h07, 5'h06, 5'h05});
        idle(1);
        check("f2_ovr_clear", {28'h0, bus.Overrun}, 32'h0);

        // Third frame, ack on channel 2 coinciding with its write
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 5'(5'h11 + j), (j == 0), (j == 2) ? 4'b0100 : 4'b0000);
            check($sformatf("f3_ovr%0d", j), {28'h0, bus.Overrun}, (j == 2) ? 32'h0 : 32'(1 << j));
        end
        check("f3_valid", {28'h0, bus.ChanValid}, 32'hF);
        check("f3_data",  {12'h0, bus.ChanData}, {12'h0, 5'h14, 5'h13, 5'h12, 5'h11});

        // Ack everything, then ack again on empty channels
        drive(1'b0, 5'h00, 1'b0, 4'hF);
        check("ack_clear", {28'h0, bus.ChanValid}, 32'h0);
        drive(1'b0, 5'h00, 1'b0, 4'hF);
        check("ack_empty_valid", {28'h0, bus.ChanValid}, 32'h0);
        check("ack_empty_data",  {12'h0, bus.ChanData}, {12'h0, 5'h14, 5'h13, 5'h12, 5'h11});

        // Sync marker arriving on slot 2 forces a resync
        drive(1'b1, 5'h15, 1'b1, 4'h0);
        drive(1'b1, 5'h16, 1'b0, 4'h0);
        drive(1'b1, 5'h0A, 1'b1, 4'h0);
        check("serr_pulse", {31'h0, bus.SyncError}, 32'h1);
        check("serr_nodone", {31'h0, bus.FrameDone}, 32'h0);
        check("serr_ch0", {27'h0, bus.ChanData[4:0]}, 32'h0A);
        drive(1'b1, 5'h0B, 1'b0, 4'h0);
        check("serr_clear", {31'h0, bus.SyncError}, 32'h0);
        drive(1'b1, 5'h0C, 1'b0, 4'h0);
        check("resync_nodone", {31'h0, bus.FrameDone}, 32'h0);
        drive(1'b1, 5'h0D, 1'b0, 4'h0);
        check("resync_done", {31'h0, bus.FrameDone}, 32'h1);
        check("resync_data", {12'h0, bus.ChanData}, {12'h0, 5'h0D, 5'h0C, 5'h0B, 5'h0A});
        check("resync_locked", {31'h0, bus.Locked}, 32'h1);

        // Idle gaps between slots
        drive(1'b0, 5'h00, 1'b0, 4'hF);
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, frame[j], (j == 0), 4'h0);
            check($sformatf("gap_done%0d", j), {31'h0, bus.FrameDone}, (j == 3) ? 32'h1 : 32'h0);
            if (j < 3) begin
                for (int g = 0; g < 3; g++) begin
                    idle(1);
                    check($sformatf("gap_idle%0d_%0d", j, g), {31'h0, bus.FrameDone}, 32'h0);
                end
            end
        end
        check("gap_data",  {12'h0, bus.ChanData}, {12'h0, 5'h04, 5'h03, 5'h02, 5'h01});
        check("gap_valid", {28'h0, bus.ChanValid}, 32'hF);

        // Asynchronous reset in the middle of a frame
        drive(1'b1, 5'h07, 1'b1, 4'h0);
        drive(1'b1, 5'h08, 1'b0, 4'h0);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 5'h09, 1'b0, 4'h0);
        check("post_rst_locked", {31'h0, bus.Locked}, 32'h0);
        check("post_rst_valid",  {28'h0, bus.ChanValid}, 32'h0);
        drive(1'b1, 5'h1C, 1'b1, 4'h0);
        check("post_rst_relock", {31'h0, bus.Locked}, 32'h1);
        check("post_rst_ch0",    {12'h0, bus.ChanData}, 32'h1C);
        check("post_rst_valid1", {28'h0, bus.ChanValid}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tdm_demux5

`default_nettype wire

// File: doc/tdm_demux5.md
# tdm_demux5

Time-division demultiplexer: the receive-side counterpart of the 2:1 address/data selectors. It takes a single time-multiplexed word stream, framed by a sync marker, and steers each slot into its own per-channel holding register. Each register carries a valid/acknowledge handshake towards its consumer. It sits between a shared serialised bus and the per-channel datapaths that the mux blocks feed.

## Interface
- WIDTH, 5, bits per word (matches the 5-bit address path)
- CHANNELS, 4, number of slots per frame / output channels (2..16)
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- InData  in  WIDTH  multiplexed word
- InValid  in  1  InData valid this cycle
- FrameSync  in  1  qualifies the current valid word as slot 0; ignored when InValid=0
- ChanAck  in  CHANNELS  consumer i has taken ChanData slice i
- ChanData  out  CHANNELS*WIDTH  slice i = bits [i*WIDTH +: WIDTH], holding register of channel i
- ChanValid  out  CHANNELS  channel i holds unconsumed data
- Overrun  out  CHANNELS  one-cycle pulse: channel i was overwritten while still valid
- FrameDone  out  1  one-cycle pulse after the last slot of a frame is stored
- SyncError  out  1  one-cycle pulse: FrameSync seen at a slot other than 0
- Locked  out  1  state machine is in RUN

## Operation
- States: HUNT, RUN. Reset → HUNT, slot counter 0.
- HUNT: words with InValid=1, FrameSync=0 are discarded. InValid=1 with FrameSync=1 stores the word in channel 0, sets slot=1 and moves to RUN.
- RUN: each InValid=1 word is stored in channel slot, and slot increments. When slot=CHANNELS-1 the word is stored, slot wraps to 0 and FrameDone pulses.
- RUN, FrameSync=1 with slot=0: normal frame start. The word goes to channel 0.
- RUN, FrameSync=1 with slot≠0: SyncError pulses. The word is stored in channel 0, slot is set to 1 (resync), and the state stays RUN. The partial frame does not raise FrameDone.
- InValid=0: no state change and no register writes.
- Channel handshake:
  - A write sets ChanValid[i].
  - ChanAck[i] with no write clears it.
  - Write and ack in the same cycle: the write wins. ChanValid stays 1 and there is no Overrun.
  - Write with ChanValid[i]=1 and no ack: data is overwritten and Overrun[i] pulses.
  - Ack on an empty channel is ignored.
- Slot counter width is clog2(CHANNELS). Counter values ≥ CHANNELS are unreachable. If one is ever reached, the block returns to HUNT.

## Timing
- All outputs are registered. Reset values: ChanData 0, ChanValid 0, Overrun 0, FrameDone 0, SyncError 0, Locked 0.
- Latency: a word accepted at edge k is visible on ChanData and ChanValid after edge k (1 cycle).
- FrameDone and SyncError are asserted in the cycle after the triggering word's edge, for exactly one cycle.
- Back-to-back InValid is supported every cycle. There is no input backpressure.
- A ChanAck sampled at edge k clears ChanValid after edge k.
- rst_n is asserted asynchronously mid-frame. All outputs clear immediately and the state becomes HUNT. Deassertion is synchronised externally; the first post-reset word needs FrameSync.

## Structure
- Shared package tdm_pkg holds:
  - the state enum {HUNT, RUN}
  - a slot-width function clog2(CHANNELS)
  - the default WIDTH/CHANNELS constants used by the mux blocks
- One natural sub-module is demux_chan_reg: a single channel with WIDTH data register, valid flag, write/ack arbitration and Overrun pulse. It is instantiated CHANNELS times by generate. The top level holds the FSM, the slot counter and the per-slot write-enable decode.

## Test plan
- Reset, then frame 0x01,0x02,0x03,0x04 with FrameSync on the first word, back-to-back. Required: ChanData slices = 01,02,03,04; ChanValid=4'b1111; one FrameDone pulse the cycle after 0x04; Locked=1.
- Words 0x1F,0x1E without FrameSync after reset. Required: discarded, ChanValid=0, Locked=0.
- A second frame without any ChanAck. Required: Overrun=4'b1111 pulsed across the four write cycles and data replaced. Repeat with ChanAck[2] in the same cycle as the slot-2 write. Required: no Overrun[2] and ChanValid[2] stays 1.
- FrameSync on the word intended for slot 2, value 0x0A. Required: SyncError pulse, channel 0=0x0A, next words land in channels 1,2,3, then FrameDone.
- InValid gaps of 3 idle cycles between slots. Required: identical channel contents; FrameDone only after the 4th valid word.
- rst_n pulsed low after slot 1. Required: all outputs 0 immediately; Locked=0 until the next FrameSync word.
